crc_capture_ctrl: RTL and testbench
===================================

Name: crc_capture_ctrl

Overview:
- Sequences the display CRC/MISR capture path for a host-programmed number of frames.
- Per frame: drives misr_cntl, tracks vsync and misr_done from the blank/sync block, and latches the MISR signature.
- Reports completion, frame count and watchdog timeout to the register interface.
- Sits between the host register bank and the blank/sync/MISR datapath, in the pixclk domain.

Parameters:
SIG_W, 48, width of the MISR signature bus (3 channels x 16 bits).
FRM_W, 8, width of the frame-count request and progress counter.
TMO_W, 24, width of the pixclk watchdog counter.

Ports:
pixclk  in  1  pixel clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a capture run.
abort  in  1  one-cycle request to cancel a run.
num_frames  in  FRM_W  frames to capture; 0 is treated as 1.
vsync  in  1  vsync from the blank/sync block.
misr_done  in  1  MISR frame-complete flag from the blank/sync block.
misr_sig  in  SIG_W  current MISR signature.
misr_cntl  out  1  capture enable to the blank/sync block.
busy  out  1  a run is in progress.
done  out  1  sticky; the run finished, normally or by timeout.
timeout_err  out  1  sticky; the watchdog expired.
frames_done  out  FRM_W  frames captured in the current or last run.
sig_out  out  SIG_W  last latched signature.

Behaviour:
- Reset values: every output is 0, state is IDLE, all internal registers are 0.
- Edge detect uses registered copies vsync_d and misr_done_d:
  - vs_fall = vsync_d & !vsync.
  - md_rise = misr_done & !misr_done_d.
- States: IDLE, ARM, CAPT, LATCH, DONE, ERR.
- IDLE:
  - On start & !abort: clear done, timeout_err and frames_done; load target = max(num_frames, 1); go to ARM.
  - Otherwise stay in IDLE.
- ARM:
  - misr_cntl = 1.
  - On vs_fall go to CAPT.
  - The MISR seeds on this vsync fall; its internal two-flop sync means misr_cntl must already have been high for 2 or more cycles.
- CAPT:
  - misr_cntl = 1.
  - On md_rise go to LATCH.
- LATCH (one cycle):
  - sig_out <= misr_sig; frames_done <= frames_done + 1.
  - If frames_done + 1 == target, go to DONE; else go to ARM.
- DONE (one cycle): done <= 1, then go to IDLE.
- ERR (one cycle): timeout_err <= 1, done <= 1, then go to IDLE.
- busy = 1 in ARM, CAPT and LATCH.
- misr_cntl = 1 only in ARM and CAPT; it is a registered output, updated on the same edge as the state.
- Watchdog:
  - TMO_W counter cleared on every entry to ARM or CAPT.
  - Increments each cycle while in ARM or CAPT.
  - On reaching all-ones, go to ERR. frames_done and sig_out keep their values.
- abort:
  - In any state other than IDLE: next state is IDLE and misr_cntl drops next cycle.
  - done, timeout_err and sig_out are not modified.
  - abort has priority over every other transition, including simultaneous md_rise or watchdog expiry.
- start while not IDLE is ignored.
- start and abort together in IDLE: abort wins; no run starts.
- vs_fall and md_rise in the same cycle while in CAPT: take the md_rise transition; the vs_fall is dropped.
- frames_done does not wrap: target is at most 2^FRM_W - 1, so its maximum is reached before overflow.
- Asynchronous reset mid-run returns all registers to reset values immediately.

Optional Feature:
- Macro: CRC_STABLE_CHECK_EN.
- When defined:
  - Adds output sig_mismatch (1 bit, sticky, reset 0, cleared on accepted start).
  - In LATCH, for the second and later frames: if misr_sig != sig_out (the previous frame's signature), set sig_mismatch <= 1.
  - No effect on state transitions.
- When undefined: no port and no compare logic; behaviour is otherwise identical.

Test Plan:
1. Reset then idle, 100 cycles of vsync toggling -> misr_cntl=0, busy=0, done=0, frames_done=0, sig_out=0.
2. num_frames=3; start; model produces misr_done per frame with sig 0xA5A5_1234_5678 -> three LATCH cycles; frames_done=3; sig_out=0xA5A51234 5678; done=1 exactly one cycle after the third LATCH; misr_cntl=0 afterward.
3. num_frames=0; start -> behaves as 1 frame; frames_done=1, done=1.
4. Watchdog shrunk to TMO_W=8, no vsync -> ERR after 255 cycles in ARM; timeout_err=1, done=1, busy=0, frames_done=0.
5. abort in CAPT on the same cycle as md_rise -> IDLE next cycle, frames_done unchanged, done stays 0; a second start while busy is ignored.
6. With CRC_STABLE_CHECK_EN, num_frames=2, sigs 0x1 then 0x2 -> sig_mismatch=1; with sigs 0x7 and 0x7 -> sig_mismatch=0.

Source files
------------

// File: rtl/crc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// crc_capture_ctrl
//
// Sequences the display CRC/MISR capture path for a host-programmed number of
// frames. For each frame it enables the MISR (misr_cntl), waits for the vsync
// falling edge that seeds the MISR, waits for the MISR frame-complete flag,
// then latches the signature. A per-frame watchdog aborts a stalled run.
// Everything runs in the pixclk domain.
//
// Optional feature (compile-time macro CRC_STABLE_CHECK_EN):
//   adds a sticky sig_mismatch output that flags any frame whose signature
//   differs from the previous frame's signature within the same run.
//
// Ports:
//   pixclk       in   pixel clock, rising-edge logic
//   reset        in   asynchronous, active-high reset
//   start        in   one-cycle request to begin a run (ignored unless idle)
//   abort        in   one-cycle request to cancel a run (highest priority)
//   num_frames   in   [FRM_W] frames to capture; 0 is treated as 1
//   vsync        in   vsync from the blank/sync block
//   misr_done    in   MISR frame-complete flag from the blank/sync block
//   misr_sig     in   [SIG_W] current MISR signature
//   misr_cntl    out  capture enable to the blank/sync block
//   busy         out  a run is in progress
//   done         out  sticky; run finished normally or by timeout
//   timeout_err  out  sticky; watchdog expired
//   frames_done  out  [FRM_W] frames captured in the current/last run
//   sig_out      out  [SIG_W] last latched signature
//   sig_mismatch out  sticky signature-instability flag (CRC_STABLE_CHECK_EN)
// -----------------------------------------------------------------------------
module crc_capture_ctrl #(
  parameter int SIG_W = 48,
  parameter int FRM_W = 8,
  parameter int TMO_W = 24
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FRM_W-1:0] num_frames,
  input  logic             vsync,
  input  logic             misr_done,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             misr_cntl,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [FRM_W-1:0] frames_done,
  output logic [SIG_W-1:0] sig_out
`ifdef CRC_STABLE_CHECK_EN
  ,
  output logic             sig_mismatch
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPT,
    ST_LATCH,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [FRM_W-1:0] FRM_ONE   = {{(FRM_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
  // The counter reaches all-ones on the same edge that moves us to ERR, so
  // expiry is decided while it still holds all-ones minus one.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e             state_q, state_d;
  logic               vsync_dly_q, misr_done_dly_q;   // registered vsync_d / misr_done_d
  logic [FRM_W-1:0]   target_q, target_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               misr_cntl_q, misr_cntl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [FRM_W-1:0]   frames_done_q, frames_done_d;
  logic [SIG_W-1:0]   sig_out_q, sig_out_d;
`ifdef CRC_STABLE_CHECK_EN
  logic               sig_mismatch_q, sig_mismatch_d;
`endif

  logic               vs_fall, md_rise, wdog_expire;
  logic [FRM_W-1:0]   frames_inc;

  assign vs_fall     = vsync_dly_q & ~vsync;
  assign md_rise     = misr_done & ~misr_done_dly_q;
  assign wdog_expire = (wdog_q == WDOG_LAST);
  assign frames_inc  = frames_done_q + FRM_ONE;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    state_d        = state_q;
    target_d       = target_q;
    done_d         = done_q;
    timeout_err_d  = timeout_err_q;
    frames_done_d  = frames_done_q;
    sig_out_d      = sig_out_q;
`ifdef CRC_STABLE_CHECK_EN
    sig_mismatch_d = sig_mismatch_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // abort in the same cycle as start cancels the start.
        if (start && !abort) begin
          done_d        = 1'b0;
          timeout_err_d = 1'b0;
          frames_done_d = '0;
          target_d      = (num_frames == '0) ? FRM_ONE : num_frames;
`ifdef CRC_STABLE_CHECK_EN
          sig_mismatch_d = 1'b0;
`endif
          state_d       = ST_ARM;
        end
      end

      ST_ARM: begin
        if (abort)            state_d = ST_IDLE;
        else if (wdog_expire) state_d = ST_ERR;
        else if (vs_fall)     state_d = ST_CAPT;
      end

      ST_CAPT: begin
        // A vs_fall coinciding with md_rise is irrelevant here: only md_rise
        // advances CAPT.
        if (abort)            state_d = ST_IDLE;
        else if (wdog_expire) state_d = ST_ERR;
        else if (md_rise)     state_d = ST_LATCH;
      end

      ST_LATCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
`ifdef CRC_STABLE_CHECK_EN
          // Compare against the previous frame's signature, which is still in
          // sig_out_q; the first frame of a run has nothing to compare with.
          if ((frames_done_q != '0) && (misr_sig != sig_out_q)) begin
            sig_mismatch_d = 1'b1;
          end
`endif
          sig_out_d     = misr_sig;
          frames_done_d = frames_inc;
          state_d       = (frames_inc == target_q) ? ST_DONE : ST_ARM;
        end
      end

      ST_DONE: begin
        if (!abort) done_d = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        if (!abort) begin
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Watchdog restarts on every state change and only counts while waiting.
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q == ST_ARM) || (state_q == ST_CAPT)) begin
      wdog_d = wdog_q + TMO_ONE;
    end else begin
      wdog_d = '0;
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    misr_cntl_d = (state_d == ST_ARM) || (state_d == ST_CAPT);
    busy_d      = (state_d == ST_ARM) || (state_d == ST_CAPT) || (state_d == ST_LATCH);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      vsync_dly_q     <= 1'b0;
      misr_done_dly_q <= 1'b0;
      target_q        <= '0;
      wdog_q          <= '0;
      misr_cntl_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      frames_done_q   <= '0;
      sig_out_q       <= '0;
`ifdef CRC_STABLE_CHECK_EN
      sig_mismatch_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      vsync_dly_q     <= vsync;
      misr_done_dly_q <= misr_done;
      target_q        <= target_d;
      wdog_q          <= wdog_d;
      misr_cntl_q     <= misr_cntl_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      timeout_err_q   <= timeout_err_d;
      frames_done_q   <= frames_done_d;
      sig_out_q       <= sig_out_d;
`ifdef CRC_STABLE_CHECK_EN
      sig_mismatch_q  <= sig_mismatch_d;
`endif
    end
  end

  assign misr_cntl    = misr_cntl_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
  assign frames_done  = frames_done_q;
  assign sig_out      = sig_out_q;
`ifdef CRC_STABLE_CHECK_EN
  assign sig_mismatch = sig_mismatch_q;
`endif

endmodule

// File: tb/tb_crc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crc_capture_ctrl
//
// Self-checking bench for crc_capture_ctrl. A table of per-cycle vectors covers
// a single-frame run with num_frames=0, hand-written sequences cover the
// multi-frame run, abort/start corner cases and the watchdog (on a second
// instance with an 8-bit watchdog), and a randomized phase is compared every
// cycle against a behavioural model of the capture rules. Inputs change 1ns
// after the rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_crc_capture_ctrl;

  localparam int SIG_W = 48;
  localparam int FRM_W = 8;
  localparam int TMO_W = 24;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;

  // Model phases (behavioural view of a run).
  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_CAPT  = 2;
  localparam int P_LATCH = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  logic             pixclk = 1'b0;
  logic             reset;
  logic             start, abort, start_w;
  logic [FRM_W-1:0] num_frames;
  logic             vsync, misr_done;
  logic [SIG_W-1:0] misr_sig;

  logic             misr_cntl, busy, done, timeout_err;
  logic [FRM_W-1:0] frames_done;
  logic [SIG_W-1:0] sig_out;
  logic             w_misr_cntl, w_busy, w_done, w_timeout_err;
  logic [FRM_W-1:0] w_frames_done;
  logic [SIG_W-1:0] w_sig_out;
`ifdef CRC_STABLE_CHECK_EN
  logic             sig_mismatch, w_sig_mismatch;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 pixclk = ~pixclk;

  crc_capture_ctrl #(.SIG_W(SIG_W), .FRM_W(FRM_W), .TMO_W(TMO_W)) dut (
    .pixclk      (pixclk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_frames  (num_frames),
    .vsync       (vsync),
    .misr_done   (misr_done),
    .misr_sig    (misr_sig),
    .misr_cntl   (misr_cntl),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .frames_done (frames_done),
    .sig_out     (sig_out)
`ifdef CRC_STABLE_CHECK_EN
    ,
    .sig_mismatch(sig_mismatch)
`endif
  );

  // Short watchdog instance for the timeout scenario.
  crc_capture_ctrl #(.SIG_W(SIG_W), .FRM_W(FRM_W), .TMO_W(8)) dut_w (
    .pixclk      (pixclk),
    .reset       (reset),
    .start       (start_w),
    .abort       (1'b0),
    .num_frames  (num_frames),
    .vsync       (vsync),
    .misr_done   (misr_done),
    .misr_sig    (misr_sig),
    .misr_cntl   (w_misr_cntl),
    .busy        (w_busy),
    .done        (w_done),
    .timeout_err (w_timeout_err),
    .frames_done (w_frames_done),
    .sig_out     (w_sig_out)
`ifdef CRC_STABLE_CHECK_EN
    ,
    .sig_mismatch(w_sig_mismatch)
`endif
  );

  typedef struct {
    logic             start;
    logic             abort;
    logic [FRM_W-1:0] nf;
    logic             vs;
    logic             md;
    logic [SIG_W-1:0] sig;
    logic             e_busy;
    logic             e_cntl;
    logic             e_done;
    logic [FRM_W-1:0] e_fd;
    logic [SIG_W-1:0] e_sig;
  } vec_t;

  vec_t vecs [8];

  // Behavioural model state.
  int               m_phase, m_wait;
  logic             m_prev_vs, m_prev_md;
  logic             m_done, m_terr, m_mis;
  logic [FRM_W-1:0] m_fd, m_target;
  logic [SIG_W-1:0] m_sig;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_wait = 0;
    m_prev_vs = 1'b0; m_prev_md = 1'b0;
    m_done = 1'b0; m_terr = 1'b0; m_mis = 1'b0;
    m_fd = '0; m_target = '0; m_sig = '0;
  endtask

  // One clock of the capture rules, applied to the inputs the DUT just sampled.
  task automatic model_step();
    bit vf, mr;
    int nxt;
    vf  = m_prev_vs && !vsync;
    mr  = misr_done && !m_prev_md;
    nxt = m_phase;
    case (m_phase)
      P_IDLE: if (start && !abort) begin
        m_done = 1'b0; m_terr = 1'b0; m_fd = '0; m_mis = 1'b0;
        m_target = (num_frames == 8'd0) ? 8'd1 : num_frames;
        nxt = P_ARM;
      end
      P_ARM, P_CAPT: begin
        if (abort) nxt = P_IDLE;
        else if (m_wait + 1 == TMO_LIMIT) nxt = P_ERR;
        else if (m_phase == P_ARM && vf) nxt = P_CAPT;
        else if (m_phase == P_CAPT && mr) nxt = P_LATCH;
      end
      P_LATCH: begin
        if (abort) nxt = P_IDLE;
        else begin
          if (m_fd != 8'd0 && misr_sig != m_sig) m_mis = 1'b1;
          m_sig = misr_sig;
          m_fd  = 8'(m_fd + 8'd1);
          nxt   = (m_fd == m_target) ? P_DONE : P_ARM;
        end
      end
      P_DONE: begin
        if (!abort) m_done = 1'b1;
        nxt = P_IDLE;
      end
      P_ERR: begin
        if (!abort) begin m_terr = 1'b1; m_done = 1'b1; end
        nxt = P_IDLE;
      end
      default: nxt = P_IDLE;
    endcase
    m_wait    = (nxt == m_phase) ? m_wait + 1 : 0;
    m_phase   = nxt;
    m_prev_vs = vsync;
    m_prev_md = misr_done;
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0; start_w = 1'b0; num_frames = '0;
    vsync = 1'b0; misr_done = 1'b0; misr_sig = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_run(input logic [FRM_W-1:0] nf);
    num_frames = nf; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_fd_clr", 64'(frames_done), 64'd0);
  endtask

  // One frame: vsync high 3 cycles, fall, wait, MISR done pulse.
  task automatic do_frame(input logic [SIG_W-1:0] s, input bit last, input logic [FRM_W-1:0] exp_fd);
    misr_sig = s; vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    misr_done = 1'b1;
    tick();
    check("frm_latch_busy", 64'(busy), 64'd1);
    check("frm_latch_cntl", 64'(misr_cntl), 64'd0);
    tick();
    check("frm_fd", 64'(frames_done), 64'(exp_fd));
    check("frm_sig", 64'(sig_out), 64'(s));
    check("frm_done_not_yet", 64'(done), 64'd0);
    misr_done = 1'b0;
    tick();
    if (last) begin
      check("frm_end_done", 64'(done), 64'd1);
      check("frm_end_busy", 64'(busy), 64'd0);
      check("frm_end_cntl", 64'(misr_cntl), 64'd0);
    end else begin
      check("frm_mid_busy", 64'(busy), 64'd1);
      check("frm_mid_cntl", 64'(misr_cntl), 64'd1);
      check("frm_mid_done", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int cnt;

    // Single-frame run with num_frames=0, one row per clock.
    //            st  ab  nf    vs  md  sig                 busy cntl done fd    sig_out
    vecs[0] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 48'h0,          1'b1, 1'b1, 1'b0, 8'd0, 48'h0};
    vecs[1] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 48'h0,          1'b1, 1'b1, 1'b0, 8'd0, 48'h0};
    vecs[2] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 48'h0,          1'b1, 1'b1, 1'b0, 8'd0, 48'h0};
    vecs[3] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 48'h0,          1'b1, 1'b1, 1'b0, 8'd0, 48'h0};
    vecs[4] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 48'h1111,       1'b1, 1'b0, 1'b0, 8'd0, 48'h0};
    vecs[5] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 48'hDEADBEEF0001, 1'b0, 1'b0, 1'b0, 8'd1, 48'hDEADBEEF0001};
    vecs[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 48'h0,          1'b0, 1'b0, 1'b1, 8'd1, 48'hDEADBEEF0001};
    vecs[7] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 48'h0,          1'b0, 1'b0, 1'b1, 8'd1, 48'hDEADBEEF0001};

    // --- Reset then idle with vsync toggling -------------------------------
    do_reset();
    check("rst_cntl", 64'(misr_cntl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_terr", 64'(timeout_err), 64'd0);
    check("rst_fd", 64'(frames_done), 64'd0);
    check("rst_sig", 64'(sig_out), 64'd0);
    for (int i = 0; i < 100; i++) begin
      vsync = ~vsync;
      tick();
    end
    check("idle_cntl", 64'(misr_cntl), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_fd", 64'(frames_done), 64'd0);
    check("idle_sig", 64'(sig_out), 64'd0);

    // --- Table: num_frames=0 behaves as one frame --------------------------
    vsync = 1'b1; misr_done = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; num_frames = vecs[i].nf;
      vsync = vecs[i].vs; misr_done = vecs[i].md; misr_sig = vecs[i].sig;
      tick();
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("vec%0d_cntl", i), 64'(misr_cntl), 64'(vecs[i].e_cntl));
      check($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].e_done));
      check($sformatf("vec%0d_fd", i), 64'(frames_done), 64'(vecs[i].e_fd));
      check($sformatf("vec%0d_sig", i), 64'(sig_out), 64'(vecs[i].e_sig));
    end
    start = 1'b0;

    // --- Three-frame run ----------------------------------------------------
    start_run(8'd3);
    do_frame(48'hA5A5_1234_5678, 1'b0, 8'd1);
    do_frame(48'hA5A5_1234_5678, 1'b0, 8'd2);
    do_frame(48'hA5A5_1234_5678, 1'b1, 8'd3);
    tick();
    check("run3_cntl_after", 64'(misr_cntl), 64'd0);
    check("run3_done_sticky", 64'(done), 64'd1);
    check("run3_terr", 64'(timeout_err), 64'd0);

    // --- start while busy ignored; abort coincident with md_rise -----------
    start_run(8'd2);
    do_frame(48'h0000_0000_0BAD, 1'b0, 8'd1);
    num_frames = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_busy", 64'(busy), 64'd1);
    check("busy_start_fd", 64'(frames_done), 64'd1);
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    tick();
    misr_done = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cntl", 64'(misr_cntl), 64'd0);
    check("abort_fd", 64'(frames_done), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sig", 64'(sig_out), 64'h0BAD);
    misr_done = 1'b0;
    repeat (3) tick();
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_idle_fd", 64'(frames_done), 64'd1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_cntl", 64'(misr_cntl), 64'd0);

    // --- Watchdog expiry on the 8-bit instance ------------------------------
    vsync = 1'b1; misr_done = 1'b0; num_frames = 8'd1;
    tick();
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    cnt = 0;
    while (w_busy && cnt < 600) begin
      cnt++;
      tick();
    end
    check("wdog_arm_cycles", 64'(cnt), 64'd255);
    tick();
    check("wdog_terr", 64'(w_timeout_err), 64'd1);
    check("wdog_done", 64'(w_done), 64'd1);
    check("wdog_busy", 64'(w_busy), 64'd0);
    check("wdog_cntl", 64'(w_misr_cntl), 64'd0);
    check("wdog_fd", 64'(w_frames_done), 64'd0);

`ifdef CRC_STABLE_CHECK_EN
    // --- Signature stability flag -------------------------------------------
    start_run(8'd2);
    do_frame(48'h1, 1'b0, 8'd1);
    do_frame(48'h2, 1'b1, 8'd2);
    check("stab_diff", 64'(sig_mismatch), 64'd1);
    start_run(8'd2);
    check("stab_clear", 64'(sig_mismatch), 64'd0);
    do_frame(48'h7, 1'b0, 8'd1);
    do_frame(48'h7, 1'b1, 8'd2);
    check("stab_same", 64'(sig_mismatch), 64'd0);
`endif

    // --- Randomized run against the behavioural model ----------------------
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      abort      = ($urandom_range(0, 63) == 0);
      num_frames = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      if ($urandom_range(0, 4) == 0) misr_done = ~misr_done;
      misr_sig   = {16'($urandom()), $urandom()};
      tick();
      model_step();
      check("rnd_busy", 64'(busy), 64'(m_phase == P_ARM || m_phase == P_CAPT || m_phase == P_LATCH));
      check("rnd_cntl", 64'(misr_cntl), 64'(m_phase == P_ARM || m_phase == P_CAPT));
      check("rnd_done", 64'(done), 64'(m_done));
      check("rnd_terr", 64'(timeout_err), 64'(m_terr));
      check("rnd_fd", 64'(frames_done), 64'(m_fd));
      check("rnd_sig", 64'(sig_out), 64'(m_sig));
`ifdef CRC_STABLE_CHECK_EN
      check("rnd_mis", 64'(sig_mismatch), 64'(m_mis));
`endif
    end

    // --- Asynchronous reset in the middle of a run ---------------------------
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; start = 1'b1; num_frames = 8'd2;
    tick();
    start = 1'b0;
    check("mid_pre_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cntl", 64'(misr_cntl), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_terr", 64'(timeout_err), 64'd0);
    check("mid_rst_fd", 64'(frames_done), 64'd0);
    check("mid_rst_sig", 64'(sig_out), 64'd0);
    check("mid_rst_w_terr", 64'(w_timeout_err), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_after_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
